pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake, the sequential successor to the single-bit full adder. The WIDTH-bit carry chain is split into STAGES equal chunks, one chunk per pipeline stage, so the clock rate is set by a WIDTH/STAGES-bit adder rather than the full word. It sits between an operand producer and a result consumer and sustains one operation per cycle when the consumer is not stalling.

---
 rtl/pipelined_adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 20 ++
 rtl/pipelined_adder.sv | 107 ++++++++++
 tb/tb_pipelined_adder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and parameter helpers for the chunked pipelined adder.
package pipelined_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Bits of the carry chain handled by each pipeline stage.
    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit slice of the carry chain; exposes the carry into its MSB for overflow.
module adder_chunk #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb_in
);

    logic [CW:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + (CW + 1)'(cin);
    assign sum      = full[CW-1:0];
    assign cout     = full[CW];
    assign c_msb_in = a[CW-1] ^ b[CW-1] ^ full[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready; one CW-bit chunk of the carry chain per stage.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned CW   = chunk_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
    end

    // Stage registers: bank k holds the state after chunk k has been added.
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q;

    // Inputs seen by each stage's adder: the capture port for stage 0, the previous bank otherwise.
    logic             src_v   [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_c   [STAGES];

    logic [CW-1:0]    ch_sum  [STAGES];
    logic             ch_cout [STAGES];
    logic             ch_cmsb [STAGES];

    logic             adv;

    assign adv      = !v_q[LAST] || out_ready;
    assign in_ready = adv && !rst;

    always_comb begin
        src_v[0]   = in_valid;
        src_a[0]   = in_a;
        src_b[0]   = in_b ^ {WIDTH{in_sub}};
        src_c[0]   = in_sub;
        src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(.CW(CW)) u_chunk (
            .a        (src_a[k][k*CW +: CW]),
            .b        (src_b[k][k*CW +: CW]),
            .cin      (src_c[k]),
            .sum      (ch_sum[k]),
            .cout     (ch_cout[k]),
            .c_msb_in (ch_cmsb[k])
        );
    end

    // Whole pipeline shifts together; operand chunks already consumed are dropped (masked to 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= src_v[k];
                a_q[k]   <= src_a[k] & ~((WIDTH'(1) << ((k + 1) * CW)) - WIDTH'(1));
                b_q[k]   <= src_b[k] & ~((WIDTH'(1) << ((k + 1) * CW)) - WIDTH'(1));
                sum_q[k] <= src_sum[k] | (WIDTH'(ch_sum[k]) << (k * CW));
                c_q[k]   <= ch_cout[k];
            end
            ovf_q <= ch_cmsb[LAST] ^ ch_cout[LAST];
        end
    end

    assign out_valid = v_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_cout  = c_q[LAST];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at 32/4, 8/1 and 16/8.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] in_a, in_b, out_sum;

    logic        s8_in_valid, s8_in_ready, s8_in_sub, s8_out_valid, s8_out_ready, s8_out_cout, s8_out_ovf;
    logic [7:0]  s8_in_a, s8_in_b, s8_out_sum;

    logic        s16_in_valid, s16_in_ready, s16_in_sub, s16_out_valid, s16_out_ready, s16_out_cout, s16_out_ovf;
    logic [15:0] s16_in_a, s16_in_b, s16_out_sum;

    int total = 0;
    int bad   = 0;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_a(s8_in_a), .in_b(s8_in_b), .in_sub(s8_in_sub),
        .out_valid(s8_out_valid), .out_ready(s8_out_ready), .out_sum(s8_out_sum), .out_cout(s8_out_cout),
        .out_ovf(s8_out_ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(8)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(s16_in_valid), .in_ready(s16_in_ready), .in_a(s16_in_a), .in_b(s16_in_b), .in_sub(s16_in_sub),
        .out_valid(s16_out_valid), .out_ready(s16_out_ready), .out_sum(s16_out_sum), .out_cout(s16_out_cout),
        .out_ovf(s16_out_ovf)
    );

    // Reference: {ovf, cout, sum} using the sign-rule definition of overflow.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb;
        logic [32:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 33'(sub);
        ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        return {ovf, full[32], full[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_sum !== 32'h0) begin bad++; $display("FAIL reset_out_sum: got %h expected 00000000", out_sum); end
        total++; if (out_cout !== 1'b0) begin bad++; $display("FAIL reset_out_cout: got %b expected 0", out_cout); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        total++; if (s16_out_valid !== 1'b0) begin bad++; $display("FAIL reset_s16_out_valid: got %b expected 0", s16_out_valid); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        total++; if (s8_in_ready !== 1'b1) begin bad++; $display("FAIL release_s8_in_ready: got %b expected 1", s8_in_ready); end
        total++; if (s16_in_ready !== 1'b1) begin bad++; $display("FAIL release_s16_in_ready: got %b expected 1", s16_in_ready); end
    endtask

    task automatic test_arith;
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vs [5];
        logic [33:0] ve [5];
        logic [33:0] got;
        int          lat;
        va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h1234_5678};
        vb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h1234_5678};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ve = '{{2'b01, 32'h0000_0000}, {2'b10, 32'h8000_0000}, {2'b00, 32'hFFFF_FFFE},
               {2'b11, 32'h7FFF_FFFF}, {2'b01, 32'h0000_0000}};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = va[i]; in_b = vb[i]; in_sub = vs[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            got = {out_ovf, out_cout, out_sum};
            total++; if (lat !== 4) begin bad++; $display("FAIL arith_latency[%0d]: got %0d expected 4", i, lat); end
            total++; if (got !== ve[i]) begin bad++; $display("FAIL arith_result[%0d]: got %h expected %h", i, got, ve[i]); end
            tick();
        end
    endtask

    task automatic test_small_configs;
        logic [7:0]  a8 [4];
        logic [7:0]  b8 [4];
        logic [15:0] a16 [4];
        logic [15:0] b16 [4];
        logic        vs [4];
        logic [9:0]  e8 [4];
        logic [17:0] e16 [4];
        logic [9:0]  g8;
        logic [17:0] g16;
        int          lat8, lat16;
        a8  = '{8'hFF, 8'h7F, 8'h05, 8'h80};
        b8  = '{8'h01, 8'h01, 8'h07, 8'h01};
        a16 = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        b16 = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
        vs  = '{1'b0, 1'b0, 1'b1, 1'b1};
        e8  = '{{2'b01, 8'h00}, {2'b10, 8'h80}, {2'b00, 8'hFE}, {2'b11, 8'h7F}};
        e16 = '{{2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        s8_out_ready = 1'b1; s16_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s8_in_a = a8[i]; s8_in_b = b8[i]; s8_in_sub = vs[i]; s8_in_valid = 1'b1;
            s16_in_a = a16[i]; s16_in_b = b16[i]; s16_in_sub = vs[i]; s16_in_valid = 1'b1;
            tick();
            s8_in_valid = 1'b0; s16_in_valid = 1'b0;
            lat8 = 0; lat16 = 0; g8 = '0; g16 = '0;
            for (int e = 1; e <= 12; e++) begin
                if (s8_out_valid && lat8 == 0) begin
                    lat8 = e; g8 = {s8_out_ovf, s8_out_cout, s8_out_sum};
                end
                if (s16_out_valid && lat16 == 0) begin
                    lat16 = e; g16 = {s16_out_ovf, s16_out_cout, s16_out_sum};
                end
                if (lat8 != 0 && lat16 != 0) break;
                tick();
            end
            total++; if (lat8 !== 1) begin bad++; $display("FAIL w8_latency[%0d]: got %0d expected 1", i, lat8); end
            total++; if (g8 !== e8[i]) begin bad++; $display("FAIL w8_result[%0d]: got %h expected %h", i, g8, e8[i]); end
            total++; if (lat16 !== 8) begin bad++; $display("FAIL w16_latency[%0d]: got %0d expected 8", i, lat16); end
            total++; if (g16 !== e16[i]) begin bad++; $display("FAIL w16_result[%0d]: got %h expected %h", i, g16, e16[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [33:0] q [$];
        logic [33:0] exp, got;
        int sent = 0, recv = 0, first = -1, last = -1;
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            logic acc;
            out_ready = 1'b1;
            #1;
            acc = in_valid && in_ready;
            if (acc) q.push_back(ref_add(in_a, in_b, in_sub));
            if (out_valid && out_ready) begin
                got = {out_ovf, out_cout, out_sum};
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_beat: got %h expected no beat", got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin bad++; $display("FAIL b2b_result[%0d]: got %h expected %h", recv, got, exp); end
                end
                recv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++; if (recv !== 8) begin bad++; $display("FAIL b2b_count: got %0d expected 8", recv); end
        total++; if (last - first !== 7) begin bad++; $display("FAIL b2b_spacing: got %0d expected 7", last - first); end
        total++; if (q.size() !== 0) begin bad++; $display("FAIL b2b_leftover: got %0d expected 0", q.size()); end
    endtask

    task automatic test_backpressure;
        logic [33:0] q [$];
        logic [33:0] exp, got;
        logic [34:0] snap, now;
        int sent = 0, recv = 0;
        snap = '0;
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            logic acc;
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            now = {out_valid, out_ovf, out_cout, out_sum};
            if (cyc == 6) begin
                snap = now;
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_at_stall: got %b expected 1", out_valid); end
            end
            if (cyc >= 6 && cyc <= 8) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
            end
            if (cyc == 7 || cyc == 8) begin
                total++; if (now !== snap) begin bad++; $display("FAIL bp_hold[%0d]: got %h expected %h", cyc, now, snap); end
            end
            acc = in_valid && in_ready;
            if (acc) q.push_back(ref_add(in_a, in_b, in_sub));
            if (out_valid && out_ready) begin
                got = {out_ovf, out_cout, out_sum};
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra_beat: got %h expected no beat", got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin bad++; $display("FAIL bp_result[%0d]: got %h expected %h", recv, got, exp); end
                end
                recv++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (recv !== 8) begin bad++; $display("FAIL bp_count: got %0d expected 8", recv); end
        total++; if (q.size() !== 0) begin bad++; $display("FAIL bp_leftover: got %0d expected 0", q.size()); end
    endtask

    task automatic test_reset_midflight;
        int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 32'h0000_0100 + 32'(i); in_b = 32'h0000_0011; in_sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid_before_rst: got %b expected 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
        total++; if (out_sum !== 32'h0) begin bad++; $display("FAIL mid_rst_out_sum: got %h expected 00000000", out_sum); end
        total++; if ({out_cout, out_ovf} !== 2'b00) begin bad++; $display("FAIL mid_rst_flags: got %b expected 00", {out_cout, out_ovf}); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_in_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale_results: got %0d expected 0", stale); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        s8_in_valid = 1'b0; s8_in_a = '0; s8_in_b = '0; s8_in_sub = 1'b0; s8_out_ready = 1'b1;
        s16_in_valid = 1'b0; s16_in_a = '0; s16_in_b = '0; s16_in_sub = 1'b0; s16_out_ready = 1'b1;
        test_reset();
        test_arith();
        test_small_configs();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
